gui_sprite_sequencer: RTL and testbench

- Animation controller for one fighter's bank of combinational sprite ROMs. Each ROM maps a 13-bit pixel_index to 16-bit RGB565 colour; 16'h0000 means transparent.
- Sequences the frame shown: idle loop, one-shot move playback, recovery.
- Arbitrates move requests against the current animation.
- Owns the registered transparency-key colour stage between the selected sprite ROM output and the background layer.

---
 rtl/gui_sprite_pkg.sv | 28 ++
 rtl/sprite_compositor.sv | 36 +++
 rtl/gui_sprite_sequencer.sv | 171 +++++++++++++++++
 tb/tb_gui_sprite_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/gui_sprite_pkg.sv
// gui_sprite_pkg
//   Shared types and constants for the fighter sprite animation slice:
//   sequencer state encoding, move identifiers, the per-move last-frame
//   table and the transparency key colour.
package gui_sprite_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    RECOVER = 2'd2
  } seq_state_e;

  localparam logic [1:0] MV_IDLE  = 2'd0;
  localparam logic [1:0] MV_SP1   = 2'd1;
  localparam logic [1:0] MV_PUNCH = 2'd2;
  localparam logic [1:0] MV_KICK  = 2'd3;

  // Index = move id. Entry 0 (idle) is unused by move playback.
  // Packed order is {kick, punch, sp1, idle}.
  localparam logic [3:0][1:0] LAST_FRAME = {2'd2, 2'd2, 2'd3, 2'd0};

  localparam logic [15:0] TRANSPARENT = 16'h0000;

  function automatic logic [1:0] last_frame(input logic [1:0] mv);
    return LAST_FRAME[mv];
  endfunction

endpackage

// File: rtl/sprite_compositor.sv
// sprite_compositor
//   Registered transparency-key mux between one sprite layer and the layer
//   beneath it. One clock of latency, independent of any animation state.
//   Ports:
//     clk, rst          clock, asynchronous active-high reset
//     pix_colour   in   RGB565 colour from the upper (sprite) layer
//     under_colour in   RGB565 colour from the lower layer
//     out_colour   out  registered composited colour
module sprite_compositor
  import gui_sprite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pix_colour,
  input  logic [15:0] under_colour,
  output logic [15:0] out_colour
);

  logic [15:0] out_colour_q;
  logic [15:0] out_colour_d;

  always_comb begin
    out_colour_d = (pix_colour != TRANSPARENT) ? pix_colour : under_colour;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_colour_q <= TRANSPARENT;
    end else begin
      out_colour_q <= out_colour_d;
    end
  end

  assign out_colour = out_colour_q;

endmodule

// File: rtl/gui_sprite_sequencer.sv
// gui_sprite_sequencer
//   Animation controller for one fighter: idle loop, one-shot move playback
//   and a cooldown (recovery) period, plus the registered transparency stage
//   feeding the OLED.
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     frame_tick  in  one-cycle pulse per display refresh; all counters
//                     advance only on these cycles
//     move_req    in  move request (level or pulse)
//     move_id     in  requested move (0 none, 1 Sp1, 2 punch, 3 kick)
//     hit_in      in  one-cycle pulse, fighter was hit
//     move_ack    out one-cycle pulse, request accepted
//     busy        out high whenever not in IDLE
//     anim_done   out one-cycle pulse, move played to completion
//     frame_sel   out {cur_move, frame}, selects the sprite ROM
//     sprite_colour in colour from the selected ROM
//     bg_colour   in  background colour for the same pixel
//     oled_colour out registered composited pixel
//   Handshake: a request is taken on any clock where the FSM is IDLE,
//   move_req=1, move_id!=0 and hit_in=0; move_ack pulses for exactly the
//   following cycle. Requests in any other state are dropped, not queued.
//   hit_in always takes priority over acceptance and over move completion.
module gui_sprite_sequencer
  import gui_sprite_pkg::*;
#(
  parameter int HOLD_TICKS     = 6,
  parameter int COOLDOWN_TICKS = 12,
  parameter int IDLE_FRAMES    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        move_req,
  input  logic [1:0]  move_id,
  input  logic        hit_in,
  output logic        move_ack,
  output logic        busy,
  output logic        anim_done,
  output logic [3:0]  frame_sel,
  input  logic [15:0] sprite_colour,
  input  logic [15:0] bg_colour,
  output logic [15:0] oled_colour
);

  localparam logic [5:0] HOLD_LAST = 6'(HOLD_TICKS - 1);
  localparam logic [5:0] CD_LAST   = 6'(COOLDOWN_TICKS - 1);
  localparam logic [1:0] IDLE_LAST = 2'(IDLE_FRAMES - 1);

  seq_state_e state_q, state_d;
  logic [1:0] cur_move_q, cur_move_d;
  logic [1:0] frame_q, frame_d;
  logic [5:0] hold_cnt_q, hold_cnt_d;
  logic [5:0] cd_cnt_q, cd_cnt_d;
  logic       move_ack_q, move_ack_d;
  logic       anim_done_q, anim_done_d;

  always_comb begin
    state_d     = state_q;
    cur_move_d  = cur_move_q;
    frame_d     = frame_q;
    hold_cnt_d  = hold_cnt_q;
    cd_cnt_d    = cd_cnt_q;
    move_ack_d  = 1'b0;
    anim_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (hit_in) begin
          state_d    = RECOVER;
          cd_cnt_d   = '0;
          cur_move_d = MV_IDLE;
          frame_d    = '0;
        end else if (move_req && (move_id != MV_IDLE)) begin
          // Acceptance wins over a coincident tick; that idle advance is lost.
          state_d    = PLAY;
          move_ack_d = 1'b1;
          cur_move_d = move_id;
          frame_d    = '0;
          hold_cnt_d = '0;
        end else if (frame_tick) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            frame_d    = (frame_q == IDLE_LAST) ? 2'd0 : frame_q + 2'd1;
          end else begin
            hold_cnt_d = hold_cnt_q + 6'd1;
          end
        end
      end

      PLAY: begin
        if (hit_in) begin
          state_d    = RECOVER;
          cd_cnt_d   = '0;
          cur_move_d = MV_IDLE;
          frame_d    = '0;
        end else if (frame_tick) begin
          if (hold_cnt_q == HOLD_LAST) begin
            hold_cnt_d = '0;
            if (frame_q == last_frame(cur_move_q)) begin
              anim_done_d = 1'b1;
              state_d     = RECOVER;
              cd_cnt_d    = '0;
              cur_move_d  = MV_IDLE;
              frame_d     = '0;
            end else begin
              frame_d = frame_q + 2'd1;
            end
          end else begin
            hold_cnt_d = hold_cnt_q + 6'd1;
          end
        end
      end

      RECOVER: begin
        // cur_move and frame were cleared on entry, so the idle pose shows.
        if (hit_in) begin
          cd_cnt_d = '0;
        end else if (frame_tick) begin
          if (cd_cnt_q == CD_LAST) begin
            state_d    = IDLE;
            hold_cnt_d = '0;
          end else begin
            cd_cnt_d = cd_cnt_q + 6'd1;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        cur_move_d = MV_IDLE;
        frame_d    = '0;
        hold_cnt_d = '0;
        cd_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cur_move_q  <= MV_IDLE;
      frame_q     <= '0;
      hold_cnt_q  <= '0;
      cd_cnt_q    <= '0;
      move_ack_q  <= 1'b0;
      anim_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_move_q  <= cur_move_d;
      frame_q     <= frame_d;
      hold_cnt_q  <= hold_cnt_d;
      cd_cnt_q    <= cd_cnt_d;
      move_ack_q  <= move_ack_d;
      anim_done_q <= anim_done_d;
    end
  end

  assign move_ack  = move_ack_q;
  assign anim_done = anim_done_q;
  assign busy      = (state_q != IDLE);
  assign frame_sel = {cur_move_q, frame_q};

  sprite_compositor u_compositor (
    .clk          (clk),
    .rst          (reset),
    .pix_colour   (sprite_colour),
    .under_colour (bg_colour),
    .out_colour   (oled_colour)
  );

endmodule

// File: tb/tb_gui_sprite_sequencer.sv
// tb_gui_sprite_sequencer
//   Directed bench for gui_sprite_sequencer with default parameters
//   (HOLD_TICKS=6, COOLDOWN_TICKS=12, IDLE_FRAMES=2).
module tb_gui_sprite_sequencer;

  logic        clk;
  logic        reset;
  logic        frame_tick;
  logic        move_req;
  logic [1:0]  move_id;
  logic        hit_in;
  logic        move_ack;
  logic        busy;
  logic        anim_done;
  logic [3:0]  frame_sel;
  logic [15:0] sprite_colour;
  logic [15:0] bg_colour;
  logic [15:0] oled_colour;

  int total = 0;
  int bad   = 0;

  logic [15:0] exp_q[$];

  gui_sprite_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .move_req      (move_req),
    .move_id       (move_id),
    .hit_in        (hit_in),
    .move_ack      (move_ack),
    .busy          (busy),
    .anim_done     (anim_done),
    .frame_sel     (frame_sel),
    .sprite_colour (sprite_colour),
    .bg_colour     (bg_colour),
    .oled_colour   (oled_colour)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock with the given inputs; returns just after the rising edge.
  task automatic step(input logic t, input logic r, input logic [1:0] id, input logic h);
    @(negedge clk);
    frame_tick = t;
    move_req   = r;
    move_id    = id;
    hit_in     = h;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
    move_req   = 1'b0;
    move_id    = 2'd0;
    hit_in     = 1'b0;
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic recover_out(input string tag);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check({tag, "_busy"}, busy, (k < 12) ? 1 : 0);
    end
  endtask

  // compositor vectors: sprite, bg, expected
  logic [15:0] cv_spr [4] = '{16'h0000, 16'h0001, 16'h0000, 16'hF64B};
  logic [15:0] cv_bg  [4] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h1234};
  logic [15:0] cv_exp [4] = '{16'h1234, 16'h0001, 16'h0000, 16'hF64B};

  initial begin
    reset         = 1'b1;
    frame_tick    = 1'b0;
    move_req      = 1'b0;
    move_id       = 2'd0;
    hit_in        = 1'b0;
    sprite_colour = 16'h0000;
    bg_colour     = 16'h0000;

    repeat (2) @(posedge clk);
    #1;
    check("rst_frame_sel", frame_sel, 4'h0);
    check("rst_busy", busy, 0);
    check("rst_ack", move_ack, 0);
    check("rst_done", anim_done, 0);
    check("rst_oled", oled_colour, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    // idle loop: frame 0 for 6 ticks, frame 1 for 6 ticks, then wrap
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("idle_loop", frame_sel, (k >= 6 && k < 12) ? 4'h1 : 4'h0);
    end
    check("idle_busy", busy, 0);

    // Sp1 accepted
    step(1'b0, 1'b1, 2'd1, 1'b0);
    check("sp1_ack", move_ack, 1);
    check("sp1_busy", busy, 1);
    check("sp1_sel0", frame_sel, 4'h4);
    for (int k = 1; k <= 24; k++) begin
      tick();
      check("sp1_sel", frame_sel, (k < 24) ? 4'(4 + k / 6) : 4'h0);
      check("sp1_done", anim_done, (k == 24) ? 1 : 0);
      if (k == 1) check("sp1_ack_pulse", move_ack, 0);
      if (k == 8) begin
        step(1'b0, 1'b1, 2'd2, 1'b0);
        check("play_req_ack", move_ack, 0);
        check("play_req_sel", frame_sel, 4'h5);
      end
    end
    check("sp1_rec_busy", busy, 1);
    step(1'b0, 1'b0, 2'd0, 1'b0);
    check("sp1_done_pulse", anim_done, 0);

    // recovery: request ignored, then back to idle after 12 ticks
    for (int k = 1; k <= 12; k++) begin
      tick();
      check("rec_busy", busy, (k < 12) ? 1 : 0);
      check("rec_sel", frame_sel, 4'h0);
      if (k == 3) begin
        step(1'b0, 1'b1, 2'd2, 1'b0);
        check("rec_req_ack", move_ack, 0);
      end
    end

    // punch accepted after returning to idle, plays 3 frames
    step(1'b0, 1'b1, 2'd2, 1'b0);
    check("punch_ack", move_ack, 1);
    check("punch_sel0", frame_sel, 4'h8);
    for (int k = 1; k <= 18; k++) begin
      tick();
      check("punch_sel", frame_sel, (k < 18) ? 4'(8 + k / 6) : 4'h0);
      check("punch_done", anim_done, (k == 18) ? 1 : 0);
    end
    recover_out("punch_rec");

    // hit together with an acceptable request: hit wins, no ack
    step(1'b0, 1'b1, 2'd1, 1'b1);
    check("hitreq_ack", move_ack, 0);
    check("hitreq_busy", busy, 1);
    check("hitreq_sel", frame_sel, 4'h0);
    recover_out("hitreq_rec");

    // kick, hit on the last-frame expiry, then re-hit at cd_cnt=5
    step(1'b0, 1'b1, 2'd3, 1'b0);
    check("kick_ack", move_ack, 1);
    check("kick_sel0", frame_sel, 4'hC);
    for (int k = 1; k <= 17; k++) tick();
    check("kick_sel_last", frame_sel, 4'hE);
    step(1'b1, 1'b0, 2'd0, 1'b1);
    check("kick_hit_done", anim_done, 0);
    check("kick_hit_busy", busy, 1);
    check("kick_hit_sel", frame_sel, 4'h0);
    for (int k = 1; k <= 5; k++) tick();
    step(1'b0, 1'b0, 2'd0, 1'b1);
    check("rehit_done", anim_done, 0);
    recover_out("rehit_rec");

    // compositor vectors
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sprite_colour = cv_spr[i];
      bg_colour     = cv_bg[i];
      exp_q.push_back(cv_exp[i]);
      @(posedge clk);
      #1;
      check("comp_oled", oled_colour, exp_q.pop_front());
    end

    // async reset mid-PLAY at frame 2
    step(1'b0, 1'b1, 2'd1, 1'b0);
    check("rstplay_ack", move_ack, 1);
    for (int k = 1; k <= 12; k++) tick();
    check("rstplay_sel", frame_sel, 4'h6);
    check("rstplay_oled_pre", oled_colour, 16'hF64B);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_sel", frame_sel, 4'h0);
    check("async_rst_busy", busy, 0);
    check("async_rst_oled", oled_colour, 16'h0000);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("post_rst_idle", frame_sel, (k == 6) ? 4'h1 : 4'h0);
    end
    check("post_rst_oled", oled_colour, 16'hF64B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
